// File: rtl/pwm_duty_capture.sv
// PWM duty capture: recovers the 4-bit duty level and per-period counts from a sampled PWM line.
// Ports: clk, rst (async active-low), pwm_in -> level, high_cnt, period_cnt, valid, period_err, stuck.
module pwm_duty_capture #(
    parameter int PERIOD_LOG2 = 4,
    parameter int CNT_W       = 8,
    parameter int TIMEOUT     = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pwm_in,
    output logic [3:0]       level,
    output logic [CNT_W-1:0] high_cnt,
    output logic [CNT_W-1:0] period_cnt,
    output logic             valid,
    output logic             period_err,
    output logic             stuck
);

    typedef enum logic [1:0] {SYNC, HIGH, LOW} state_t;

    localparam logic [CNT_W-1:0] ONES = '1;
    localparam logic [CNT_W-1:0] NOM  = CNT_W'(2 ** PERIOD_LOG2);
    localparam logic [CNT_W-1:0] TMO  = CNT_W'(TIMEOUT);

    state_t           state, state_nx;
    logic             s1, s, s_d;
    logic [1:0]       warm;
    logic [CNT_W-1:0] hc, pc, hc_nx, pc_nx, tcnt;
    logic             live, rise, fall, edge_any;
    logic             commit, tmo_hit;
    logic [CNT_W+3:0] scaled;
    logic [3:0]       lvl;

    function automatic logic [CNT_W-1:0] inc(input logic [CNT_W-1:0] v);
        return (v == ONES) ? v : v + 1'b1;
    endfunction

    // Edges are ignored until the edge-detect flop holds a real sample,
    // so a line already high at reset release is not seen as a rise.
    assign live     = (warm == 2'd3);
    assign rise     = live & s & ~s_d;
    assign fall     = live & ~s & s_d;
    assign edge_any = rise | fall;
    assign commit   = (state == LOW) & rise;
    assign tmo_hit  = live & ~stuck & ~edge_any & (tcnt == TMO - 1'b1);

    assign scaled = {hc, 4'b0000} >> PERIOD_LOG2;
    assign lvl    = (|scaled[CNT_W+3:4]) ? 4'hF : scaled[3:0];

    always_comb begin
        state_nx = state;
        hc_nx    = hc;
        pc_nx    = pc;
        if (tmo_hit) begin
            state_nx = SYNC;
        end else begin
            case (state)
                SYNC: begin
                    if (rise) begin
                        state_nx = HIGH;
                        hc_nx    = CNT_W'(1);
                        pc_nx    = CNT_W'(1);
                    end
                end
                HIGH: begin
                    pc_nx = inc(pc);
                    if (fall) state_nx = LOW;
                    else      hc_nx    = inc(hc);
                end
                LOW: begin
                    if (rise) begin
                        state_nx = HIGH;
                        hc_nx    = CNT_W'(1);
                        pc_nx    = CNT_W'(1);
                    end else begin
                        pc_nx = inc(pc);
                    end
                end
                default: state_nx = SYNC;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1    <= 1'b0;
            s     <= 1'b0;
            s_d   <= 1'b0;
            warm  <= 2'd0;
            state <= SYNC;
            hc    <= '0;
            pc    <= '0;
            tcnt  <= '0;
        end else begin
            s1    <= pwm_in;
            s     <= s1;
            s_d   <= s;
            if (!live) warm <= warm + 2'd1;
            state <= state_nx;
            hc    <= hc_nx;
            pc    <= pc_nx;
            if (!live || edge_any) tcnt <= '0;
            else                   tcnt <= inc(tcnt);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            level      <= 4'd0;
            high_cnt   <= '0;
            period_cnt <= '0;
            valid      <= 1'b0;
            period_err <= 1'b0;
            stuck      <= 1'b0;
        end else begin
            valid <= 1'b0;
            if (commit) begin
                valid      <= 1'b1;
                high_cnt   <= hc;
                period_cnt <= pc;
                period_err <= (pc != NOM);
                level      <= lvl;
                stuck      <= 1'b0;
            end else if (tmo_hit) begin
                valid      <= 1'b1;
                stuck      <= 1'b1;
                period_err <= 1'b1;
                level      <= s ? 4'hF : 4'h0;
                high_cnt   <= s ? ONES : '0;
                period_cnt <= s ? ONES : '0;
            end else if (edge_any) begin
                stuck <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pwm_duty_capture.sv
// Self-checking bench for pwm_duty_capture: randomized and directed PWM
// waveforms compared against a period-level reference model.
module tb_pwm_duty_capture;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       pwm_in = 1'b0;
    logic [3:0] level;
    logic [7:0] high_cnt;
    logic [7:0] period_cnt;
    logic       valid;
    logic       period_err;
    logic       stuck;

    int n_cmp = 0;
    int n_bad = 0;

    // record = {period_err, level, high_cnt, period_cnt}
    logic [20:0] obs_q[$];
    logic [20:0] exp_q[$];

    pwm_duty_capture #(.PERIOD_LOG2(4), .CNT_W(8), .TIMEOUT(64)) dut (
        .clk(clk),
        .rst(rst),
        .pwm_in(pwm_in),
        .level(level),
        .high_cnt(high_cnt),
        .period_cnt(period_cnt),
        .valid(valid),
        .period_err(period_err),
        .stuck(stuck)
    );

    always #5 clk = ~clk;

    always @(negedge clk)
        if (rst === 1'b1 && valid === 1'b1)
            obs_q.push_back({period_err, level, high_cnt, period_cnt});

    function automatic logic [20:0] model(input int h, input int l);
        int lv, hc, pc;
        hc = (h > 255) ? 255 : h;
        pc = (h + l > 255) ? 255 : h + l;
        lv = (hc * 16) / 16;
        if (lv > 15) lv = 15;
        return {(pc != 16), 4'(lv), 8'(hc), 8'(pc)};
    endfunction

    task automatic do_reset();
        @(negedge clk);
        pwm_in = 1'b0;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        obs_q.delete();
        exp_q.delete();
        rst = 1'b1;
        repeat (6) @(negedge clk);
    endtask

    // Drives n full periods plus a closing rise; expectation per period.
    task automatic drive_seq(input int n, input int hs[8], input int ls[8]);
        for (int i = 0; i < n; i++) begin
            pwm_in = 1'b1;
            repeat (hs[i]) @(negedge clk);
            pwm_in = 1'b0;
            repeat (ls[i]) @(negedge clk);
            exp_q.push_back(model(hs[i], ls[i]));
        end
        pwm_in = 1'b1;
        repeat (2) @(negedge clk);
        pwm_in = 1'b0;
        repeat (10) @(negedge clk);
    endtask

    task automatic test_reset();
        pwm_in = 1'b1;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({level, high_cnt, period_cnt, valid, period_err, stuck} !== 23'd0) begin
            n_bad++;
            $display("FAIL reset_state: got %h want 0",
                     {level, high_cnt, period_cnt, valid, period_err, stuck});
        end
    endtask

    task automatic test_basic();
        int hs[8] = '{5, 5, 5, 0, 0, 0, 0, 0};
        int ls[8] = '{11, 11, 11, 0, 0, 0, 0, 0};
        do_reset();
        drive_seq(3, hs, ls);
        n_cmp++;
        if (obs_q.size() !== exp_q.size()) begin
            n_bad++;
            $display("FAIL basic_count: got %0d want %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_cmp++;
            if (obs_q[i] !== exp_q[i]) begin
                n_bad++;
                $display("FAIL basic_rec%0d: got %h want %h", i, obs_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int hs[8] = '{12, 3, 10, 20, 1, 0, 0, 0};
        int ls[8] = '{4, 13, 10, 2, 1, 0, 0, 0};
        do_reset();
        drive_seq(5, hs, ls);
        n_cmp++;
        if (obs_q.size() !== exp_q.size()) begin
            n_bad++;
            $display("FAIL b2b_count: got %0d want %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_cmp++;
            if (obs_q[i] !== exp_q[i]) begin
                n_bad++;
                $display("FAIL b2b_rec%0d: got %h want %h", i, obs_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_random();
        int hs[8];
        int ls[8];
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 8; i++) begin
                hs[i] = $urandom_range(1, 24);
                ls[i] = $urandom_range(1, 24);
            end
            do_reset();
            drive_seq(8, hs, ls);
            n_cmp++;
            if (obs_q.size() !== exp_q.size()) begin
                n_bad++;
                $display("FAIL rand%0d_count: got %0d want %0d", r, obs_q.size(), exp_q.size());
            end
            for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
                n_cmp++;
                if (obs_q[i] !== exp_q[i]) begin
                    n_bad++;
                    $display("FAIL rand%0d_rec%0d: got %h want %h", r, i, obs_q[i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_stuck_low();
        int hs[8] = '{8, 8, 0, 0, 0, 0, 0, 0};
        int ls[8] = '{8, 8, 0, 0, 0, 0, 0, 0};
        int cyc;
        do_reset();
        cyc = 6;
        while (stuck !== 1'b1 && cyc < 120) begin
            @(negedge clk);
            cyc++;
        end
        n_cmp++;
        if (cyc < 64 || cyc > 72) begin
            n_bad++;
            $display("FAIL stuck_low_time: got %0d cycles want 64..72", cyc);
        end
        repeat (80 - 64) @(negedge clk);
        exp_q.push_back({1'b1, 4'd0, 8'd0, 8'd0});
        n_cmp++;
        if (stuck !== 1'b1) begin
            n_bad++;
            $display("FAIL stuck_low_flag: got %b want 1", stuck);
        end
        drive_seq(2, hs, ls);
        n_cmp++;
        if (stuck !== 1'b0) begin
            n_bad++;
            $display("FAIL stuck_low_clear: got %b want 0", stuck);
        end
        n_cmp++;
        if (obs_q.size() !== exp_q.size()) begin
            n_bad++;
            $display("FAIL stuck_low_count: got %0d want %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_cmp++;
            if (obs_q[i] !== exp_q[i]) begin
                n_bad++;
                $display("FAIL stuck_low_rec%0d: got %h want %h", i, obs_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_stuck_high();
        do_reset();
        pwm_in = 1'b1;
        repeat (80) @(negedge clk);
        exp_q.push_back({1'b1, 4'd15, 8'd255, 8'd255});
        n_cmp++;
        if (stuck !== 1'b1) begin
            n_bad++;
            $display("FAIL stuck_high_flag: got %b want 1", stuck);
        end
        n_cmp++;
        if (obs_q.size() !== 1) begin
            n_bad++;
            $display("FAIL stuck_high_count: got %0d want 1", obs_q.size());
        end
        if (obs_q.size() > 0) begin
            n_cmp++;
            if (obs_q[0] !== exp_q[0]) begin
                n_bad++;
                $display("FAIL stuck_high_rec: got %h want %h", obs_q[0], exp_q[0]);
            end
        end
    endtask

    task automatic test_reset_mid();
        int hs[8] = '{5, 6, 0, 0, 0, 0, 0, 0};
        int ls[8] = '{11, 10, 0, 0, 0, 0, 0, 0};
        do_reset();
        drive_seq(1, hs, ls);
        pwm_in = 1'b1;
        repeat (3) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        n_cmp++;
        if ({level, high_cnt, period_cnt, valid, period_err, stuck} !== 23'd0) begin
            n_bad++;
            $display("FAIL reset_mid_async: got %h want 0",
                     {level, high_cnt, period_cnt, valid, period_err, stuck});
        end
        @(negedge clk);
        obs_q.delete();
        exp_q.delete();
        rst = 1'b1;
        repeat (6) @(negedge clk);
        pwm_in = 1'b0;
        repeat (10) @(negedge clk);
        drive_seq(2, hs, ls);
        n_cmp++;
        if (obs_q.size() !== exp_q.size()) begin
            n_bad++;
            $display("FAIL reset_mid_count: got %0d want %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_cmp++;
            if (obs_q[i] !== exp_q[i]) begin
                n_bad++;
                $display("FAIL reset_mid_rec%0d: got %h want %h", i, obs_q[i], exp_q[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_random();
        test_stuck_low();
        test_stuck_high();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
